// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO read-side transmit controller.
package fifo_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned ACK_TIMEOUT_DEF = 4;
  localparam int unsigned XFER_CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_e;

  // Counter width able to hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// FIFO read port plus downstream serializer handshake.
interface async_fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  r_inc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;

  modport master (
    input  rempty, rd_data, tx_busy,
    output r_inc, tx_data, tx_valid
  );

  modport slave (
    output rempty, rd_data, tx_busy,
    input  r_inc, tx_data, tx_valid
  );
endinterface

// File: rtl/ack_timer.sv
// Counts WAIT_HI cycles; expire_c flags the last allowed cycle before a resend.
module ack_timer
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Pops one word at a time from a FIFO and hands it to a busy-handshaked serializer.
module async_fifo_rd_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  en,
  async_fifo_rd_ctrl_if.master  bus,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  timeout_err
);

  state_e state_q, state_d;

  logic                  r_inc_q, r_inc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  ack_clr_c, ack_en_c, ack_expire_c;

  ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk      (r_clk),
    .rst_n    (rrst_n),
    .clear    (ack_clr_c),
    .enable   (ack_en_c),
    .expire_c (ack_expire_c)
  );

  always_ff @(posedge r_clk) begin
    if (!rrst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Ack arrival beats timeout when both happen in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (en && !bus.rempty && !bus.tx_busy) state_d = ST_POP;
      ST_POP:     state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.tx_busy)       state_d = ST_WAIT_LO;
        else if (ack_expire_c) state_d = ST_SEND;
      end
      ST_WAIT_LO: if (!bus.tx_busy) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_comb begin
    r_inc_d       = (state_d == ST_POP);
    tx_valid_d    = (state_d == ST_SEND);
    tx_data_d     = tx_data_q;
    xfer_cnt_d    = xfer_cnt_q;
    timeout_err_d = timeout_err_q;
    ack_clr_c     = (state_q == ST_SEND);
    ack_en_c      = (state_q == ST_WAIT_HI);
    if (state_q == ST_POP) tx_data_d = bus.rd_data;
    if (state_q == ST_WAIT_LO && state_d == ST_IDLE) xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
    if (state_q == ST_WAIT_HI && state_d == ST_SEND) timeout_err_d = 1'b1;
  end

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      r_inc_q       <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      xfer_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      r_inc_q       <= r_inc_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      xfer_cnt_q    <= xfer_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.r_inc    = r_inc_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign xfer_cnt     = xfer_cnt_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench: small FIFO and serializer models around the read controller.
module tb_async_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       en;
  logic [7:0] xfer_cnt;
  logic       timeout_err;

  async_fifo_rd_ctrl_if #(.DATA_WIDTH(8)) bus ();

  async_fifo_rd_ctrl #(.DATA_WIDTH(8), .ACK_TIMEOUT(4)) dut (
    .r_clk       (clk),
    .rrst_n      (rrst_n),
    .en          (en),
    .bus         (bus),
    .xfer_cnt    (xfer_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] log_q[$];
  int cyc = 0;
  int n_rinc, n_txv, busy_left, hold, last_txv, gap_min, gap_max;
  bit pend_pop;

  task automatic drive();
    bus.rempty  = (q.size() == 0);
    bus.rd_data = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic reset_model();
    q.delete();
    log_q.delete();
    pend_pop  = 1'b0;
    busy_left = 0;
    hold      = 1;
    n_rinc    = 0;
    n_txv     = 0;
    last_txv  = -1;
    gap_min   = 1000;
    gap_max   = 0;
    bus.tx_busy = 1'b0;
    drive();
  endtask

  // One clock: retire the popped word, run the serializer, record outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pend_pop) begin
      if (q.size() != 0) q.delete(0);
      pend_pop = 1'b0;
    end
    bus.tx_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (bus.r_inc === 1'b1) begin
      n_rinc++;
      pend_pop = 1'b1;
    end
    if (bus.tx_valid === 1'b1) begin
      n_txv++;
      log_q.push_back(bus.tx_data);
      if (last_txv >= 0) begin
        if (cyc - last_txv < gap_min) gap_min = cyc - last_txv;
        if (cyc - last_txv > gap_max) gap_max = cyc - last_txv;
      end
      last_txv  = cyc;
      busy_left = hold;
    end
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    en     = 1'b0;
    reset_model();
    ticks(2);
    rrst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    en     = 1'b1;
    reset_model();
    q.push_back(8'h5A);
    drive();
    ticks(3);
    total++; if (bus.r_inc !== 1'b0) begin bad++; $display("FAIL rst_r_inc: got %b want 0", bus.r_inc); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL rst_xfer_cnt: got %0d want 0", xfer_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    total++; if (n_rinc !== 0) begin bad++; $display("FAIL rst_no_pop: got %0d pops want 0", n_rinc); end
  endtask

  task automatic test_single();
    do_reset();
    hold = 10;
    q.push_back(8'hA5);
    en = 1'b1;
    drive();
    tick();
    total++; if (bus.r_inc !== 1'b1) begin bad++; $display("FAIL single_pop_cycle: got %b want 1", bus.r_inc); end
    tick();
    total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_send: got valid=%b data=%h want 1/a5", bus.tx_valid, bus.tx_data); end
    ticks(10);
    total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL single_busy_hold: got xfer=%0d want 0", xfer_cnt); end
    ticks(8);
    total++; if (n_rinc !== 1) begin bad++; $display("FAIL single_rinc_count: got %0d want 1", n_rinc); end
    total++; if (n_txv !== 1) begin bad++; $display("FAIL single_txv_count: got %0d want 1", n_txv); end
    total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data_held: got %h want a5", bus.tx_data); end
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL single_xfer_cnt: got %0d want 1", xfer_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_empty();
    do_reset();
    en = 1'b1;
    drive();
    ticks(20);
    total++; if (n_rinc !== 0) begin bad++; $display("FAIL empty_rinc: got %0d want 0", n_rinc); end
    total++; if (n_txv !== 0) begin bad++; $display("FAIL empty_txv: got %0d want 0", n_txv); end
    total++; if (xfer_cnt !== 8'd0 || bus.tx_data !== 8'h00) begin bad++; $display("FAIL empty_idle: got xfer=%0d data=%h want 0/00", xfer_cnt, bus.tx_data); end
  endtask

  task automatic test_timeout();
    do_reset();
    hold = 0;
    q.push_back(8'h3C);
    en = 1'b1;
    drive();
    ticks(6);
    total++; if (n_txv !== 1 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_before: got txv=%0d err=%b want 1/0", n_txv, timeout_err); end
    hold = 1;
    tick();
    total++; if (n_txv !== 2) begin bad++; $display("FAIL to_resend_count: got %0d want 2", n_txv); end
    total++; if (gap_min !== 5) begin bad++; $display("FAIL to_resend_gap: got %0d want 5", gap_min); end
    total++; if (log_q[0] !== 8'h3C || log_q[1] !== 8'h3C) begin bad++; $display("FAIL to_resend_data: got %h/%h want 3c/3c", log_q[0], log_q[1]); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    total++; if (n_rinc !== 1) begin bad++; $display("FAIL to_single_pop: got %0d want 1", n_rinc); end
    ticks(6);
    total++; if (xfer_cnt !== 8'd1 || n_txv !== 2) begin bad++; $display("FAIL to_complete: got xfer=%0d txv=%0d want 1/2", xfer_cnt, n_txv); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
    do_reset();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_cleared: got %b want 0", timeout_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hold = 1;
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    en = 1'b1;
    drive();
    ticks(16);
    total++; if (n_txv !== 3) begin bad++; $display("FAIL b2b_txv_count: got %0d want 3", n_txv); end
    total++; if (n_txv == 3 && (log_q[0] !== 8'h01 || log_q[1] !== 8'h02 || log_q[2] !== 8'h03)) begin bad++; $display("FAIL b2b_data_seq: got %h %h %h want 01 02 03", log_q[0], log_q[1], log_q[2]); end
    total++; if (gap_min !== 5 || gap_max !== 5) begin bad++; $display("FAIL b2b_spacing: got min=%0d max=%0d want 5/5", gap_min, gap_max); end
    total++; if (xfer_cnt !== 8'd3) begin bad++; $display("FAIL b2b_xfer_cnt: got %0d want 3", xfer_cnt); end
    total++; if (n_rinc !== 3) begin bad++; $display("FAIL b2b_rinc_count: got %0d want 3", n_rinc); end
  endtask

  task automatic test_en_drop();
    do_reset();
    hold = 3;
    q.push_back(8'h11);
    q.push_back(8'h22);
    en = 1'b1;
    drive();
    ticks(4);
    en = 1'b0;
    ticks(10);
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL endrop_complete: got %0d want 1", xfer_cnt); end
    total++; if (n_rinc !== 1 || n_txv !== 1) begin bad++; $display("FAIL endrop_no_pop: got rinc=%0d txv=%0d want 1/1", n_rinc, n_txv); end
    total++; if (bus.tx_data !== 8'h11) begin bad++; $display("FAIL endrop_data_held: got %h want 11", bus.tx_data); end
    en = 1'b1;
    ticks(8);
    total++; if (xfer_cnt !== 8'd2 || bus.tx_data !== 8'h22) begin bad++; $display("FAIL endrop_resume: got xfer=%0d data=%h want 2/22", xfer_cnt, bus.tx_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold = 1;
    q.push_back(8'h66);
    q.push_back(8'h77);
    en = 1'b1;
    drive();
    ticks(6);
    hold = 0;
    ticks(2);
    total++; if (xfer_cnt !== 8'd1 || bus.tx_data !== 8'h77) begin bad++; $display("FAIL rmid_pre: got xfer=%0d data=%h want 1/77", xfer_cnt, bus.tx_data); end
    rrst_n = 1'b0;
    tick();
    total++; if (bus.r_inc !== 1'b0 || bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rmid_strobes: got rinc=%b txv=%b want 0/0", bus.r_inc, bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00 || xfer_cnt !== 8'd0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rmid_regs: got data=%h xfer=%0d err=%b want 00/0/0", bus.tx_data, xfer_cnt, timeout_err); end
    rrst_n = 1'b1;
    ticks(6);
    total++; if (n_rinc !== 2 || n_txv !== 2) begin bad++; $display("FAIL rmid_no_extra: got rinc=%0d txv=%0d want 2/2", n_rinc, n_txv); end
  endtask

  initial begin
    rrst_n = 1'b0;
    en     = 1'b0;
    reset_model();
    test_reset();
    test_single();
    test_empty();
    test_timeout();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
